multicycle_control: RTL and testbench

- Moore FSM that sequences the 16-bit CPU datapath over fetch/decode/execute/memory/writeback cycles.
- Drives the 2-bit ALUOp consumed by ALU control: 00 add (lw/sw address), 01 subtract (beq/bne compare), 10 R-format by Funct, 11 I-format by opcode.
- Also drives PC, IR, memory and register-file enables.
- Stalls on a memory ready handshake.

---
 rtl/cpu_defs.sv | 52 +++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_control.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle CPU control path.
// Holds the opcode map, the ALUOp / ALUSrcB / PCSrc encodings and the
// control FSM state encodings, which are visible on StateOut.
package cpu_defs;

    // Opcodes, IR[15:12]
    localparam logic [3:0] OP_R0   = 4'b0000;
    localparam logic [3:0] OP_R1   = 4'b0001;
    localparam logic [3:0] OP_R2   = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_BNE  = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_SUBI = 4'b1010;
    localparam logic [3:0] OP_SLTI = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // ALUOp consumed by ALU control
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_TWO   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_HOLD   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_HALT   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory handshake.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset, clears the count
//   clear   - synchronous clear (entering a new wait state)
//   enable  - count this cycle (waiting, no ready)
//   expired - the current cycle is the timeout-th waiting cycle
module mem_wait_timer #(
    parameter int unsigned Timeout = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count holds cycles already waited; the cycle where it equals
    // Timeout-1 is the Timeout-th waiting cycle.
    localparam logic [3:0] Limit = 4'(Timeout - 1);

    logic [3:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= 4'd0;
        end else if (enable && (count_q != 4'hf)) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign expired = (count_q >= Limit);

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the 16-bit multicycle CPU datapath.
// Sequences fetch/decode/execute/memory/writeback and stalls on MemReady.
// Ports:
//   Clock, Reset          - clock, synchronous active-high reset
//   Opcode, Zero          - IR[15:12] and ALU zero flag
//   MemReady              - memory access completes this cycle
//   PCWrite, PCSrc        - PC load enable and source select
//   IorD, MemRead/Write   - memory address select and requests
//   IRWrite               - instruction register load
//   ALUSrcA/B, ALUOp      - ALU operand selects and operation class
//   RegDst, MemToReg,
//   RegWrite              - register-file write controls
//   Halted, BusError      - sticky status (held by HALT / ERROR states)
//   IllegalOp             - single-cycle pulse on an undefined opcode
//   StateOut              - current state encoding
module multicycle_control
    import cpu_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       Halted,
    output logic       BusError,
    output logic       IllegalOp,
    output logic [3:0] StateOut
);

    state_t state_q, state_d;
    logic   wait_state;
    logic   timer_expired;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    // Any state change restarts the count, so every wait state starts from zero.
    mem_wait_timer #(
        .Timeout (MEM_TIMEOUT)
    ) u_timer (
        .clk     (Clock),
        .rst     (Reset),
        .clear   (state_d != state_q),
        .enable  (wait_state && !MemReady),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        PCSrc     = PCSRC_HOLD;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = ALUSRCB_REG;
        ALUOp     = ALUOP_ADD;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        Halted    = 1'b0;
        BusError  = 1'b0;
        IllegalOp = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUSRCB_TWO;
                // Ready wins over a timeout landing in the same cycle.
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PCSRC_ALU;
                    state_d = S_DECODE;
                end else if (timer_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                ALUSrcB = ALUSRCB_IMMSH;
                case (Opcode)
                    OP_R0, OP_R1, OP_R2:    state_d = S_EXEC_R;
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:         state_d = S_BRANCH;
                    OP_ADDI, OP_SUBI,
                    OP_SLTI:                state_d = S_EXEC_I;
                    OP_HALT:                state_d = S_HALT;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
                state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end else if (timer_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end else if (timer_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_R;
                state_d = S_WB_R;
            end
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
                ALUOp   = ALUOP_I;
                state_d = S_WB_I;
            end
            S_WB_I: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_TARGET;
                PCWrite = (Opcode == OP_BNE) ? ~Zero : Zero;
                state_d = S_FETCH;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            S_ERROR: begin
                BusError = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign StateOut = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes a hand-built
// expected output vector per cycle, the monitor pops and compares on the
// falling edge.
module tb_multicycle_control;

    logic       Clock, Reset, Zero, MemReady;
    logic [3:0] Opcode;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic       RegDst, MemToReg, RegWrite, Halted, BusError, IllegalOp;
    logic [3:0] StateOut;

    multicycle_control #(
        .MEM_TIMEOUT (15)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Opcode    (Opcode),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .RegDst    (RegDst),
        .MemToReg  (MemToReg),
        .RegWrite  (RegWrite),
        .Halted    (Halted),
        .BusError  (BusError),
        .IllegalOp (IllegalOp),
        .StateOut  (StateOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    // Vector layout: state, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite,
    // ALUSrcA, ALUSrcB, ALUOp, RegDst, MemToReg, RegWrite, Halted, BusError, IllegalOp
    function automatic logic [21:0] mk(input logic [3:0] st, input logic pcw,
                                       input logic [1:0] pcs, input logic iord,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic rd,
                                       input logic m2r, input logic rw, input logic h,
                                       input logic be, input logic il);
        return {st, pcw, pcs, iord, mr, mw, irw, asa, asb, aop, rd, m2r, rw, h, be, il};
    endfunction

    // Monitor
    exp_t        cur;
    logic [21:0] act;
    always @(negedge Clock) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            act = {StateOut, PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, ALUSrcA,
                   ALUSrcB, ALUOp, RegDst, MemToReg, RegWrite, Halted, BusError, IllegalOp};
            checks++;
            if (act !== cur.v) begin
                fails++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.v);
            end
        end
    end

    task automatic step(input logic r, input logic [3:0] op, input logic z,
                        input logic mr, input logic chk, input string nm,
                        input logic [21:0] v);
        exp_t e;
        Reset    = r;
        Opcode   = op;
        Zero     = z;
        MemReady = mr;
        if (chk) begin
            e.name = nm;
            e.v    = v;
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
    endtask

    logic [21:0] f_wait, f_rdy, dec, dec_il, madr, mrd, mwb, mwr;
    logic [21:0] exr, wbr, exi, wbi, br_t, br_n, hlt, err;

    initial begin
        f_wait = mk(4'd0,  0, 2'b10, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        f_rdy  = mk(4'd0,  1, 2'b00, 0, 1, 0, 1, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
        dec    = mk(4'd1,  0, 2'b10, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0);
        dec_il = mk(4'd1,  0, 2'b10, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1);
        madr   = mk(4'd2,  0, 2'b10, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
        mrd    = mk(4'd3,  0, 2'b10, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        mwb    = mk(4'd4,  0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0);
        mwr    = mk(4'd5,  0, 2'b10, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        exr    = mk(4'd6,  0, 2'b10, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
        wbr    = mk(4'd7,  0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0);
        exi    = mk(4'd8,  0, 2'b10, 0, 0, 0, 0, 1, 2'b10, 2'b11, 0, 0, 0, 0, 0, 0);
        wbi    = mk(4'd9,  0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0);
        br_t   = mk(4'd10, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
        br_n   = mk(4'd10, 0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0);
        hlt    = mk(4'd11, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
        err    = mk(4'd12, 0, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);

        // Reset for two cycles; the second one already shows FETCH.
        step(1, 4'h1, 0, 1, 0, "rst0", '0);
        step(1, 4'h1, 0, 1, 1, "reset_fetch", f_rdy);

        // R-format 0001: 0,1,6,7,0
        step(0, 4'h1, 0, 1, 1, "r_fetch", f_rdy);
        step(0, 4'h1, 0, 1, 1, "r_decode", dec);
        step(0, 4'h1, 0, 1, 1, "r_exec", exr);
        step(0, 4'h1, 0, 1, 1, "r_wb", wbr);

        // LW with three wait cycles in MEMRD
        step(0, 4'h4, 0, 1, 1, "lw_fetch", f_rdy);
        step(0, 4'h4, 0, 1, 1, "lw_decode", dec);
        step(0, 4'h4, 0, 1, 1, "lw_memadr", madr);
        repeat (3) step(0, 4'h4, 0, 0, 1, "lw_memrd_wait", mrd);
        step(0, 4'h4, 0, 1, 1, "lw_memrd_rdy", mrd);
        step(0, 4'h4, 0, 1, 1, "lw_memwb", mwb);

        // SW, zero wait
        step(0, 4'h5, 0, 1, 1, "sw_fetch", f_rdy);
        step(0, 4'h5, 0, 1, 1, "sw_decode", dec);
        step(0, 4'h5, 0, 1, 1, "sw_memadr", madr);
        step(0, 4'h5, 0, 1, 1, "sw_memwr", mwr);

        // Branches, both polarities of Zero
        step(0, 4'h6, 1, 1, 1, "beq_fetch", f_rdy);
        step(0, 4'h6, 1, 1, 1, "beq_decode", dec);
        step(0, 4'h6, 1, 1, 1, "beq_z1", br_t);
        step(0, 4'h7, 1, 1, 1, "bne_fetch", f_rdy);
        step(0, 4'h7, 1, 1, 1, "bne_decode", dec);
        step(0, 4'h7, 1, 1, 1, "bne_z1", br_n);
        step(0, 4'h6, 0, 1, 1, "beq0_fetch", f_rdy);
        step(0, 4'h6, 0, 1, 1, "beq0_decode", dec);
        step(0, 4'h6, 0, 1, 1, "beq_z0", br_n);
        step(0, 4'h7, 0, 1, 1, "bne0_fetch", f_rdy);
        step(0, 4'h7, 0, 1, 1, "bne0_decode", dec);
        step(0, 4'h7, 0, 1, 1, "bne_z0", br_t);

        // ADDI and SLTI
        step(0, 4'h9, 0, 1, 1, "addi_fetch", f_rdy);
        step(0, 4'h9, 0, 1, 1, "addi_decode", dec);
        step(0, 4'h9, 0, 1, 1, "addi_exec", exi);
        step(0, 4'h9, 0, 1, 1, "addi_wb", wbi);
        step(0, 4'hb, 0, 1, 1, "slti_fetch", f_rdy);
        step(0, 4'hb, 0, 1, 1, "slti_decode", dec);
        step(0, 4'hb, 0, 1, 1, "slti_exec", exi);
        step(0, 4'hb, 0, 1, 1, "slti_wb", wbi);

        // Illegal opcodes 0011 and 1000
        step(0, 4'h3, 0, 1, 1, "ill3_fetch", f_rdy);
        step(0, 4'h3, 0, 1, 1, "ill3_decode", dec_il);
        step(0, 4'h3, 0, 0, 1, "ill3_after", f_wait);
        step(0, 4'h8, 0, 1, 1, "ill8_fetch", f_rdy);
        step(0, 4'h8, 0, 1, 1, "ill8_decode", dec_il);

        // Ready on the 15th waiting cycle beats the timeout
        repeat (14) step(0, 4'h0, 0, 0, 1, "fetch_wait14", f_wait);
        step(0, 4'h0, 0, 1, 1, "fetch_rdy15", f_rdy);
        step(0, 4'h0, 0, 1, 1, "r0_decode", dec);
        step(0, 4'h0, 0, 1, 1, "r0_exec", exr);
        step(0, 4'h0, 0, 1, 1, "r0_wb", wbr);

        // Timeout: 15 waiting cycles, then sticky ERROR
        repeat (15) step(0, 4'h0, 0, 0, 1, "fetch_wait15", f_wait);
        step(0, 4'h0, 0, 1, 1, "error0", err);
        repeat (3) step(0, 4'h0, 0, 1, 1, "error_stay", err);
        step(1, 4'h1, 0, 1, 1, "error_in_reset", err);
        step(0, 4'h1, 0, 1, 1, "error_cleared", f_rdy);
        step(0, 4'h1, 0, 1, 1, "post_err_decode", dec);
        step(0, 4'h1, 0, 1, 1, "post_err_exec", exr);
        step(0, 4'h1, 0, 1, 1, "post_err_wb", wbr);

        // HALT holds for 20 cycles regardless of MemReady
        step(0, 4'hf, 0, 1, 1, "halt_fetch", f_rdy);
        step(0, 4'hf, 0, 1, 1, "halt_decode", dec);
        for (int i = 0; i < 20; i++) step(0, 4'hf, 1'(i), 1'(i >> 1), 1, "halted", hlt);
        step(1, 4'h5, 0, 1, 1, "halt_in_reset", hlt);

        // Reset in the middle of a MEMWR stall
        step(0, 4'h5, 0, 1, 1, "sw2_fetch", f_rdy);
        step(0, 4'h5, 0, 1, 1, "sw2_decode", dec);
        step(0, 4'h5, 0, 1, 1, "sw2_memadr", madr);
        repeat (2) step(0, 4'h5, 0, 0, 1, "sw2_memwr_wait", mwr);
        step(1, 4'h5, 0, 0, 1, "sw2_memwr_reset", mwr);
        step(0, 4'h5, 0, 0, 1, "sw2_after_reset", f_wait);

        repeat (2) @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
